// File: rtl/bus_requester_pkg.sv
// Shared types for the bus requester slice.
// State encoding and wait-counter sizing helper.
package bus_requester_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Bits needed to hold 0..t inclusive.
  function automatic int wait_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/bus_requester_sync_fifo.sv
// Synchronous FIFO with a look-ahead head output.
// The head is readable in the same cycle it is popped.
module sync_fifo
  import bus_requester_pkg::*;
#(
  parameter int width = 9,
  parameter int depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full_o    = (count_q == CW'(depth));
  assign empty_o   = (count_q == '0);
  assign wr_ok     = wr_en_i & ~full_o;
  assign rd_ok     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap at a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset flushes the contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; stale entries are harmless once pointers reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/bus_requester.sv
// Client-side bus requester: buffers packets, requests,
// streams granted words, then yields the bus for a cycle.
module bus_requester
  import bus_requester_pkg::*;
#(
  parameter int data_width = 8,
  parameter int depth      = 4,
  parameter int timeout    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push_valid,
  output logic                  o_push_ready,
  input  logic [data_width-1:0] i_push_data,
  input  logic                  i_push_last,
  output logic                  o_request,
  input  logic                  i_grant,
  output logic                  o_bus_valid,
  output logic [data_width-1:0] o_bus_data,
  output logic                  o_bus_last,
  output logic                  o_timeout
);

  localparam int WW = wait_width(timeout);
  localparam int PW = $clog2(depth) + 1;

  localparam logic [WW-1:0] TO_MAX = WW'(timeout);
  localparam logic [WW-1:0] TO_PRE = WW'(timeout - 1);

  state_e              state_q;
  logic                req_q;
  logic                to_q;
  logic [WW-1:0]       wait_q;
  logic [PW-1:0]       pkts_q;
  logic [PW-1:0]       pkts_d;

  logic [data_width:0] head;
  logic                full;
  logic                empty;
  logic                push_acc;
  logic                push_last;
  logic                pop;
  logic                pop_last;
  logic                counting;

  assign push_acc  = i_push_valid & ~full;
  assign push_last = push_acc & i_push_last;
  assign pop       = (state_q == XFER) & i_grant & ~empty;
  assign pop_last  = pop & head[data_width];
  assign counting  = req_q & ~i_grant;

  assign o_push_ready = ~full;
  assign o_request    = req_q;
  assign o_timeout    = to_q;
  assign o_bus_valid  = pop;
  assign o_bus_data   = head[data_width-1:0];
  assign o_bus_last   = pop_last;

  sync_fifo #(
    .width (data_width + 1),
    .depth (depth)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (push_acc),
    .wr_data_i ({i_push_last, i_push_data}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Complete packets held: +1 on stored last, -1 on sent last.
  always_comb begin
    pkts_d = pkts_q;
    unique case ({push_last, pop_last})
      2'b10:   pkts_d = pkts_q + PW'(1);
      2'b01:   pkts_d = pkts_q - PW'(1);
      default: pkts_d = pkts_q;
    endcase
  end

  // Packet counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkts_q <= '0;
    end else begin
      pkts_q <= pkts_d;
    end
  end

  // Request FSM with the wait counter and registered pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      to_q    <= 1'b0;
      wait_q  <= '0;
    end else begin
      to_q <= counting & (wait_q == TO_PRE);
      if (counting) begin
        wait_q <= (wait_q == TO_MAX) ? '0 : wait_q + WW'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (pkts_q != '0) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (i_grant) begin
            state_q <= XFER;
            wait_q  <= '0;
          end
        end
        XFER: begin
          if (pop_last) begin
            state_q <= RELEASE;
            req_q   <= 1'b0;
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_requester.sv
// Self-checking bench for bus_requester.
// Queue-based reference model plus directed checks.
module tb_bus_requester;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int T     = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_push_valid;
  logic          o_push_ready;
  logic [DW-1:0] i_push_data;
  logic          i_push_last;
  logic          o_request;
  logic          i_grant;
  logic          o_bus_valid;
  logic [DW-1:0] o_bus_data;
  logic          o_bus_last;
  logic          o_timeout;

  bus_requester #(
    .data_width (DW),
    .depth      (DEPTH),
    .timeout    (T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (i_push_valid),
    .o_push_ready (o_push_ready),
    .i_push_data  (i_push_data),
    .i_push_last  (i_push_last),
    .o_request    (o_request),
    .i_grant      (i_grant),
    .o_bus_valid  (o_bus_valid),
    .o_bus_data   (o_bus_data),
    .o_bus_last   (o_bus_last),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: FIFO contents, request/ownership flags,
  // cumulative waiting cycles since the last clear.
  logic [DW-1:0] m_dat [$];
  bit            m_lst [$];
  bit            m_req, m_owner, m_cool, m_to, live;
  int            m_w;

  // Observation logs for directed checks.
  int            beat_cyc [$];
  logic [DW-1:0] beat_dat [$];
  bit            beat_lst [$];
  int            rise_q [$];
  int            fall_q [$];
  int            to_q [$];

  initial begin
    bit pop_now, pop_lst, acc, waiting;
    int pk;
    live = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst === 1'b1) begin
        m_dat.delete();
        m_lst.delete();
        m_req = 0; m_owner = 0; m_cool = 0;
        m_to = 0; m_w = 0; live = 1;
      end else if (live) begin
        pk = 0;
        foreach (m_lst[i]) if (m_lst[i]) pk++;
        pop_now = m_owner && (i_grant === 1'b1)
                  && (m_dat.size() > 0);
        pop_lst = pop_now && m_lst[0];
        acc = (i_push_valid === 1'b1)
              && (m_dat.size() < DEPTH);
        waiting = m_req && (i_grant !== 1'b1);
        m_to = waiting && ((m_w % (T + 1)) == T - 1);
        if (waiting) m_w++;
        if (m_cool) begin
          m_cool = 0;
        end else if (!m_req) begin
          if (pk > 0) m_req = 1;
        end else if (!m_owner) begin
          if (i_grant === 1'b1) begin
            m_owner = 1;
            m_w = 0;
          end
        end else if (pop_lst) begin
          m_owner = 0; m_req = 0; m_cool = 1;
        end
        if (pop_now) begin
          void'(m_dat.pop_front());
          void'(m_lst.pop_front());
        end
        if (acc) begin
          m_dat.push_back(i_push_data);
          m_lst.push_back(i_push_last);
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus logging.
  initial begin
    bit ev, el, prev_req;
    prev_req = 0;
    forever begin
      @(negedge clk);
      if (live) begin
        ev = m_owner && (i_grant === 1'b1)
             && (m_dat.size() > 0);
        el = ev ? m_lst[0] : 1'b0;
        chk("push_ready", 32'(o_push_ready),
            32'(m_dat.size() < DEPTH));
        chk("request", 32'(o_request), 32'(m_req));
        chk("bus_valid", 32'(o_bus_valid), 32'(ev));
        chk("bus_last", 32'(o_bus_last), 32'(el));
        chk("timeout", 32'(o_timeout), 32'(m_to));
        if (ev) chk("bus_data", 32'(o_bus_data), 32'(m_dat[0]));
        if (o_bus_valid === 1'b1) begin
          beat_cyc.push_back(cyc);
          beat_dat.push_back(o_bus_data);
          beat_lst.push_back(o_bus_last === 1'b1);
        end
        if (o_request === 1'b1 && !prev_req) rise_q.push_back(cyc);
        if (o_request !== 1'b1 && prev_req) fall_q.push_back(cyc);
        if (o_timeout === 1'b1) to_q.push_back(cyc);
        prev_req = (o_request === 1'b1);
      end
    end
  end

  int last_push_cyc;

  task automatic clear_logs();
    beat_cyc.delete(); beat_dat.delete(); beat_lst.delete();
    rise_q.delete(); fall_q.delete(); to_q.delete();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1; i_push_valid = 0; i_grant = 0;
    step(1);
    rst = 0;
    step(1);
    clear_logs();
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    logic acc;
    int k;
    i_push_valid = 1; i_push_data = d; i_push_last = l;
    acc = 0; k = 0;
    while (!acc && k < 50) begin
      acc = o_push_ready;
      last_push_cyc = cyc;
      step(1);
      k++;
    end
    i_push_valid = 0;
    chk("push_accept", 32'(acc), 32'(1));
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (beat_dat.size() < n && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_beats", 32'(beat_dat.size() >= n), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] e1 [3];
    logic [DW-1:0] e2 [4];
    logic [DW-1:0] e4 [4];
    int t_push, k;
    e1 = '{8'h11, 8'h22, 8'h33};
    e2 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    e4 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    rst = 1; i_push_valid = 0; i_push_data = '0;
    i_push_last = 0; i_grant = 0;
    step(2);
    rst = 0;
    @(negedge clk);
    chk("rst_request", 32'(o_request), 32'(0));
    chk("rst_valid", 32'(o_bus_valid), 32'(0));
    chk("rst_last", 32'(o_bus_last), 32'(0));
    chk("rst_timeout", 32'(o_timeout), 32'(0));
    chk("rst_ready", 32'(o_push_ready), 32'(1));
    @(posedge clk); #1;
    clear_logs();

    // Single packet, grant tied high.
    i_grant = 1;
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
    t_push = last_push_cyc;
    wait_beats(3, 40);
    step(6);
    chk("t1_rises", 32'(rise_q.size()), 32'(1));
    chk("t1_falls", 32'(fall_q.size()), 32'(1));
    chk("t1_beats", 32'(beat_dat.size()), 32'(3));
    if (rise_q.size() == 1 && beat_dat.size() == 3
        && fall_q.size() == 1) begin
      chk("t1_req_lat", 32'(rise_q[0] - t_push), 32'(2));
      for (int i = 0; i < 3; i++) begin
        chk("t1_data", 32'(beat_dat[i]), 32'(e1[i]));
        chk("t1_last", 32'(beat_lst[i]), 32'(i == 2));
        chk("t1_beat_cyc", 32'(beat_cyc[i] - rise_q[0]),
            32'(i + 1));
      end
      chk("t1_release", 32'(fall_q[0] - beat_cyc[2]), 32'(1));
    end

    // Grant drop for two cycles after beat 2.
    do_reset();
    i_grant = 1;
    push(8'hA1, 0); push(8'hA2, 0); push(8'hA3, 0); push(8'hA4, 1);
    wait_beats(2, 20);
    i_grant = 0;
    step(2);
    i_grant = 1;
    wait_beats(4, 20);
    step(3);
    chk("t2_beats", 32'(beat_dat.size()), 32'(4));
    chk("t2_falls", 32'(fall_q.size()), 32'(1));
    chk("t2_timeouts", 32'(to_q.size()), 32'(0));
    if (beat_dat.size() == 4 && fall_q.size() == 1) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_data", 32'(beat_dat[i]), 32'(e2[i]));
        chk("t2_last", 32'(beat_lst[i]), 32'(i == 3));
      end
      chk("t2_gap01", 32'(beat_cyc[1] - beat_cyc[0]), 32'(1));
      chk("t2_gap12", 32'(beat_cyc[2] - beat_cyc[1]), 32'(3));
      chk("t2_gap23", 32'(beat_cyc[3] - beat_cyc[2]), 32'(1));
      chk("t2_req_held", 32'(fall_q[0] - beat_cyc[3]), 32'(1));
    end

    // Timeout with grant low for 8 request cycles.
    do_reset();
    push(8'h5A, 0); push(8'hA5, 1);
    t_push = last_push_cyc;
    step(9);
    i_grant = 1;
    wait_beats(2, 20);
    step(3);
    chk("t3_rises", 32'(rise_q.size()), 32'(1));
    chk("t3_pulses", 32'(to_q.size()), 32'(2));
    chk("t3_beats", 32'(beat_dat.size()), 32'(2));
    chk("t3_falls", 32'(fall_q.size()), 32'(1));
    if (rise_q.size() == 1 && to_q.size() == 2
        && beat_dat.size() == 2 && fall_q.size() == 1) begin
      chk("t3_req_lat", 32'(rise_q[0] - t_push), 32'(2));
      chk("t3_pulse0", 32'(to_q[0] - rise_q[0]), 32'(3));
      chk("t3_pulse1", 32'(to_q[1] - rise_q[0]), 32'(7));
      chk("t3_beat0", 32'(beat_cyc[0] - rise_q[0]), 32'(9));
      chk("t3_data0", 32'(beat_dat[0]), 32'(8'h5A));
      chk("t3_data1", 32'(beat_dat[1]), 32'(8'hA5));
      chk("t3_release", 32'(fall_q[0] - beat_cyc[1]), 32'(1));
    end

    // Back-pressure: four single-word packets fill the FIFO.
    do_reset();
    for (int i = 0; i < 4; i++) push(e4[i], 1);
    chk("t4_full", 32'(o_push_ready), 32'(0));
    i_push_valid = 1; i_push_data = 8'hEE; i_push_last = 1;
    i_grant = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_bus_valid !== 1'b1 && k < 20);
    chk("t4_pop_seen", 32'(o_bus_valid), 32'(1));
    chk("t4_refused", 32'(o_push_ready), 32'(0));
    @(posedge clk); #1;
    i_push_valid = 0;
    wait_beats(4, 40);
    step(6);
    chk("t4_beats", 32'(beat_dat.size()), 32'(4));
    chk("t4_falls", 32'(fall_q.size()), 32'(4));
    chk("t4_rises", 32'(rise_q.size()), 32'(4));
    if (beat_dat.size() == 4 && fall_q.size() == 4
        && rise_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t4_data", 32'(beat_dat[i]), 32'(e4[i]));
        chk("t4_last", 32'(beat_lst[i]), 32'(1));
        chk("t4_release", 32'(fall_q[i] - beat_cyc[i]), 32'(1));
      end
      for (int i = 0; i < 3; i++) begin
        chk("t4_spacing", 32'(beat_cyc[i+1] - beat_cyc[i]), 32'(4));
        chk("t4_rerequest", 32'(rise_q[i+1] - beat_cyc[i]), 32'(3));
      end
    end

    // Reset in the middle of a transfer.
    do_reset();
    i_grant = 1;
    push(8'hC1, 0); push(8'hC2, 0); push(8'hC3, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_bus_valid !== 1'b1 && k < 20);
    chk("t5_beat1", 32'(o_bus_data), 32'(8'hC1));
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t5_request", 32'(o_request), 32'(0));
    chk("t5_valid", 32'(o_bus_valid), 32'(0));
    chk("t5_last", 32'(o_bus_last), 32'(0));
    chk("t5_timeout", 32'(o_timeout), 32'(0));
    chk("t5_ready", 32'(o_push_ready), 32'(1));
    step(8);
    chk("t5_no_more", 32'(beat_dat.size()), 32'(1));
    chk("t5_no_req", 32'(rise_q.size()), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
